reaction_ctrl: RTL and testbench
================================

Name: reaction_ctrl

Overview:
Sequences one reaction-time trial around the PWM LED driver. On `start` it waits a pseudo-random delay, then asserts `bright` to the PWM block. It measures the milliseconds until the subject's key press and reports the result. A press before the LED lights is reported as a foul. It sits between the debounced key/start inputs and the PWM block's `bright` input, and feeds the result display.

Parameters:
TICK_DIV, 100000, clock cycles per 1 ms tick (100 MHz clk); ≥2
MIN_DELAY_MS, 1000, minimum wait before LED on; ≥1
RAND_BITS, 11, number of LFSR bits added to the delay (0..2^RAND_BITS-1 ms); 1..15
MAX_MS, 9999, reaction-time saturation/timeout value; <2^14

Ports:
clk  input  1  system clock, 100 MHz
rstn  input  1  asynchronous active-low reset
start  input  1  synchronous, debounced; level-sensitive, acted on only in IDLE/DONE/FOUL
key  input  1  synchronous, debounced response key, active-high level
bright  output  1  LED-on request to PWM block
busy  output  1  high in WAIT or LIT
result_ms  output  14  last reaction time in ms
result_valid  output  1  high in DONE
foul  output  1  high in FOUL

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, all outputs 0, result_ms=0.
  - LFSR=16'hACE1; key_q=0; tick and delay counters 0.
  - Reset mid-trial aborts immediately; `bright` drops asynchronously.
- Key edge: key_q registers key each cycle; key_rise = key & ~key_q. Only rises count, so a key already held at start is ignored until released and pressed again.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states; never all-zero.
- ms tick:
  - Counter 0..TICK_DIV-1 runs only in WAIT and LIT; cleared to 0 on every state entry.
  - tick=1 in the cycle the counter equals TICK_DIV-1, so the first tick occurs on the TICK_DIV-th cycle in the state.
- States (all outputs decode from the registered state):
  - IDLE: start=1 → WAIT.
  - WAIT:
    - On entry, delay_cnt loads MIN_DELAY_MS + LFSR[RAND_BITS-1:0] from the cycle start was sampled.
    - key_rise → FOUL.
    - On tick: if delay_cnt==1 → LIT, else delay_cnt decrements.
    - key_rise and the expiring tick in the same cycle → FOUL (foul wins).
  - LIT:
    - bright=1; rt_cnt cleared on entry and incremented on each tick.
    - key_rise → DONE, result_ms latched from rt_cnt (value before any same-cycle increment).
    - tick with rt_cnt==MAX_MS-1 → DONE, result_ms=MAX_MS (timeout).
  - DONE: result_valid=1. start → WAIT; result_valid clears on leaving; result_ms holds until the next latch.
  - FOUL: foul=1, result_ms unchanged. start → WAIT.
- Start handling:
  - start in WAIT/LIT is ignored.
  - start held continuously in DONE/FOUL re-arms once per entry.
- Output values per state:
  - busy=1 exactly in WAIT and LIT.
  - bright=1 exactly in LIT.
  - result_valid and foul are never both 1.
- Widths: delay_cnt 16 bits; rt_cnt 14 bits; tick counter ceil(log2(TICK_DIV)) bits.

Test Plan (TICK_DIV=10, MIN_DELAY_MS=2, RAND_BITS=2, MAX_MS=20):
1. Reset with key=0, start=0 → all outputs 0. Assert rstn mid-LIT → bright=0 immediately, state IDLE.
2. Pulse start; no key → bright rises after 2..5 ticks (20..50 cycles + 1) and stays high. Timeout at the 20th tick in LIT → result_ms=20, result_valid=1, bright=0.
3. Normal trial: key rises 35 cycles after bright rises (LIT cycle index 35) → result_ms=3, DONE, result_valid=1, busy=0.
4. Foul: key rises 5 cycles into WAIT → foul=1, bright never asserts, result_ms keeps its previous value. Then start → WAIT, foul=0.
5. Edge cases:
   - key held high across start: no foul, no result.
   - key released then pressed in LIT: measured normally.
   - key rise on the expiring WAIT tick: FOUL.
   - key rise on a LIT tick: result excludes that tick.
6. Back-to-back: start held high through DONE → new WAIT entered the next cycle. Over 200 trials, every LIT→bright delay lies in 2..5 ms and all four values 2, 3, 4, 5 occur.

Source files
------------

// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-time trial sequencer driving the PWM LED bright request
//
// Ports:
//   clk          system clock (100 MHz nominal)
//   rstn         asynchronous active-low reset
//   start        debounced start request, acted on in IDLE/DONE/FOUL
//   key          debounced response key, active high
//   bright       LED-on request to the PWM block (high in LIT)
//   busy         trial in progress (WAIT or LIT)
//   result_ms    last measured reaction time in ms
//   result_valid high in DONE
//   foul         high in FOUL (key pressed before the LED lit)
module reaction_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        key,
    output logic        bright,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        foul
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        LIT  = 3'd2,
        DONE = 3'd3,
        FOUL = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   lfsr;
    logic          key_q;
    logic [TW-1:0] tick_cnt;
    logic [15:0]   delay_cnt;
    logic [13:0]   rt_cnt;
    logic [13:0]   result_reg;

    logic          key_rise;
    logic          timing;
    logic          tick;
    logic          entering;
    logic          latch_rt;
    logic          latch_max;
    logic [15:0]   delay_load;

    assign key_rise = key & ~key_q;
    assign timing   = (state == WAIT) || (state == LIT);
    assign tick     = timing && (tick_cnt == TW'(TICK_DIV - 1));
    assign entering = (state_next != state);

    // Random part of the wait comes from the LFSR value present in the
    // cycle the start request is sampled.
    assign delay_load = 16'(MIN_DELAY_MS)
                      + {{(16 - RAND_BITS){1'b0}}, lfsr[RAND_BITS-1:0]};

    always_comb begin
        state_next = state;
        latch_rt   = 1'b0;
        latch_max  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT;
            end
            WAIT: begin
                // A key rise always fouls, even on the tick that would light the LED.
                if (key_rise) begin
                    state_next = FOUL;
                end else if (tick && (delay_cnt == 16'd1)) begin
                    state_next = LIT;
                end
            end
            LIT: begin
                if (key_rise) begin
                    state_next = DONE;
                    latch_rt   = 1'b1;
                end else if (tick && (rt_cnt == 14'(MAX_MS - 1))) begin
                    state_next = DONE;
                    latch_max  = 1'b1;
                end
            end
            DONE, FOUL: begin
                if (start) state_next = WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            lfsr       <= 16'hACE1;
            key_q      <= 1'b0;
            tick_cnt   <= '0;
            delay_cnt  <= 16'd0;
            rt_cnt     <= 14'd0;
            result_reg <= 14'd0;
        end else begin
            state <= state_next;
            key_q <= key;
            // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed never reaches zero.
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            // ms prescaler restarts on every state change so each state
            // sees its first tick on its TICK_DIV-th cycle.
            if (entering || !timing || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (entering && (state_next == WAIT)) begin
                delay_cnt <= delay_load;
            end else if ((state == WAIT) && tick) begin
                delay_cnt <= delay_cnt - 16'd1;
            end

            if (entering && (state_next == LIT)) begin
                rt_cnt <= 14'd0;
            end else if ((state == LIT) && tick && (state_next == LIT)) begin
                rt_cnt <= rt_cnt + 14'd1;
            end

            if (latch_rt) begin
                result_reg <= rt_cnt;
            end else if (latch_max) begin
                result_reg <= 14'(MAX_MS);
            end
        end
    end

    assign bright       = (state == LIT);
    assign busy         = (state == WAIT) || (state == LIT);
    assign result_valid = (state == DONE);
    assign foul         = (state == FOUL);
    assign result_ms    = result_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - scoreboard bench for reaction_ctrl
module tb_reaction_ctrl;

    localparam int TICK_DIV = 10;
    localparam int MIN_MS   = 2;
    localparam int RBITS    = 2;
    localparam int MAX_MS   = 20;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        key = 1'b0;
    logic        bright;
    logic        busy;
    logic [13:0] result_ms;
    logic        result_valid;
    logic        foul;

    reaction_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .MIN_DELAY_MS(MIN_MS),
        .RAND_BITS   (RBITS),
        .MAX_MS      (MAX_MS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .key         (key),
        .bright      (bright),
        .busy        (busy),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .foul        (foul)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference LFSR, taps 16,14,13,11, used to predict each trial's delay.
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct {
        bit is_foul;
        int ms;
    } exp_t;
    exp_t exp_q[$];
    int   last_ms = 0;
    bit   seen[4];

    task automatic expect_done(input int ms);
        exp_t e;
        e.is_foul = 1'b0;
        e.ms      = ms;
        exp_q.push_back(e);
        last_ms = ms;
    endtask

    task automatic expect_foul();
        exp_t e;
        e.is_foul = 1'b1;
        e.ms      = last_ms;
        exp_q.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_foul"}, 32'(foul), 32'(e.is_foul));
            check_eq({tag, "_valid"}, 32'(result_valid), 32'(!e.is_foul));
            check_eq({tag, "_ms"}, 32'(result_ms), 32'(e.ms));
            check_eq({tag, "_idle"}, 32'({busy, bright}), 32'd0);
        end
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(result_valid || foul) && n < 400);
        if (n >= 400) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        compare_head(tag);
    endtask

    // Called at a negedge in IDLE/DONE/FOUL; returns at WAIT cycle 0.
    task automatic begin_trial(input string tag, output int d);
        d = MIN_MS + int'(lfsr_m[RBITS-1:0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, 32'({busy, foul, result_valid}), 32'b100);
    endtask

    // Called at WAIT cycle 0; returns at LIT cycle 0.
    task automatic wait_lit(input string tag, input int d);
        int n;
        n = 0;
        while (!bright && !foul && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_delay_cycles"}, 32'(n), 32'(d * TICK_DIV));
        if (n % TICK_DIV == 0 && n / TICK_DIV >= 2 && n / TICK_DIV <= 5) seen[n / TICK_DIV - 2] = 1'b1;
    endtask

    // Called at LIT cycle 0; key rises in LIT cycle k.
    task automatic press_at(input string tag, input int k);
        repeat (k) @(negedge clk);
        key = 1'b1;
        expect_done(k / TICK_DIV);
        collect(tag);
        key = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        bit got_two;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'({bright, busy, result_valid, foul}), 32'd0);
        check_eq("rst_result", 32'(result_ms), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // No key: LED lights after the predicted delay, then times out
        begin_trial("to", d);
        wait_lit("to", d);
        expect_done(MAX_MS);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_valid && n < 400);
        check_eq("to_cycles", 32'(n), 32'(MAX_MS * TICK_DIV));
        compare_head("to");

        // Normal trial
        begin_trial("norm", d);
        wait_lit("norm", d);
        press_at("norm", 35);

        // Foul 5 cycles into WAIT, result keeps previous value
        begin_trial("foul", d);
        repeat (5) @(negedge clk);
        key = 1'b1;
        expect_foul();
        collect("foul");
        key = 1'b0;
        begin_trial("refoul", d);
        wait_lit("refoul", d);
        press_at("refoul", 12);

        // Key held across start: no foul, then release and press in LIT
        key = 1'b1;
        begin_trial("held", d);
        wait_lit("held", d);
        check_eq("held_nofoul", 32'({foul, bright}), 32'b01);
        key = 1'b0;
        press_at("held", 17);

        // Key rise on LIT ticks: the tick itself is excluded
        begin_trial("ltick", d);
        wait_lit("ltick", d);
        press_at("ltick", 29);
        begin_trial("ltick9", d);
        wait_lit("ltick9", d);
        press_at("ltick9", 9);

        // Key rise on the expiring WAIT tick (needs a 2 ms delay)
        got_two = 1'b0;
        for (int a = 0; a < 60 && !got_two; a++) begin
            begin_trial("wtick", d);
            if (d == 2) begin
                got_two = 1'b1;
                repeat (2 * TICK_DIV - 1) @(negedge clk);
                key = 1'b1;
                expect_foul();
                collect("wtick");
                key = 1'b0;
            end else begin
                wait_lit("wtick_skip", d);
                press_at("wtick_skip", 5);
            end
        end
        check_eq("wtick_found", 32'(got_two), 32'd1);

        // Start held through LIT and DONE: ignored in LIT, re-arms from DONE
        begin_trial("b2b", d);
        wait_lit("b2b", d);
        start = 1'b1;
        repeat (14) @(negedge clk);
        check_eq("b2b_lit_hold", 32'({bright, busy}), 32'b11);
        key = 1'b1;
        expect_done(1);
        collect("b2b");
        d = MIN_MS + int'(lfsr_m[RBITS-1:0]);
        key = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_rearm", 32'({busy, result_valid}), 32'b10);
        wait_lit("b2b2", d);
        press_at("b2b2", 3);

        // Many trials: every delay in range, all delay values seen
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        for (int t = 0; t < 200; t++) begin
            begin_trial("loop", d);
            wait_lit("loop", d);
            press_at("loop", int'($urandom_range(80, 1)));
        end
        check_eq("delays_seen", 32'({seen[0], seen[1], seen[2], seen[3]}), 32'b1111);

        // Asynchronous reset in the middle of LIT
        begin_trial("arst", d);
        wait_lit("arst", d);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_async", 32'({bright, busy, result_valid, foul}), 32'd0);
        check_eq("arst_result", 32'(result_ms), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
